// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: mem_op codes, FSM encoding,
// timeout limit and the size/fault/byte-enable decode helpers.
package mem_pkg;

   localparam logic [4:0] OP_LW  = 5'b01000;
   localparam logic [4:0] OP_LHU = 5'b01001;
   localparam logic [4:0] OP_LB  = 5'b01010;
   localparam logic [4:0] OP_LH  = 5'b01011;
   localparam logic [4:0] OP_LBU = 5'b01100;
   localparam logic [4:0] OP_SW  = 5'b01101;
   localparam logic [4:0] OP_SH  = 5'b01110;
   localparam logic [4:0] OP_SB  = 5'b01111;

   localparam int NUM_LANES     = 4;
   localparam int TIMEOUT_LIMIT = 15;
   localparam int TMO_W         = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_t;

   // Request captured on acceptance; everything downstream works from this copy.
   typedef struct packed {
      logic        rw;
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   function automatic size_t op_size(input logic [4:0] op);
      size_t s;
      case (op)
         OP_LW, OP_SW:          s = SZ_WORD;
         OP_LH, OP_LHU, OP_SH:  s = SZ_HALF;
         OP_LB, OP_LBU, OP_SB:  s = SZ_BYTE;
         default:               s = SZ_NONE;
      endcase
      return s;
   endfunction

   function automatic logic op_is_load(input logic [4:0] op);
      return (op == OP_LW) || (op == OP_LHU) || (op == OP_LB) ||
             (op == OP_LH) || (op == OP_LBU);
   endfunction

   // Undefined code, misalignment, or rw disagreeing with the code's direction.
   function automatic logic op_fault(input logic rw, input logic [4:0] op,
                                     input logic [1:0] a);
      logic f;
      case (op_size(op))
         SZ_WORD: f = (a != 2'b00);
         SZ_HALF: f = a[0];
         SZ_BYTE: f = 1'b0;
         default: f = 1'b1;
      endcase
      return f | (rw != op_is_load(op));
   endfunction

   function automatic logic [3:0] op_be(input logic [4:0] op, input logic [1:0] a);
      logic [3:0] be;
      case (op_size(op))
         SZ_WORD: be = 4'b1111;
         SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: be = 4'b0001 << a;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension (little-endian lanes).
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr,
   input  logic [4:0]  i_mem_op,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed lane and extend it according to the op.
   always_comb begin
      w_byte   = i_word[{i_addr, 3'b000} +: 8];
      w_half   = i_addr[1] ? i_word[31:16] : i_word[15:0];
      o_result = '0;
      case (i_mem_op)
         OP_LW:   o_result = i_word;
         OP_LH:   o_result = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_result = {16'h0000, w_half};
         OP_LB:   o_result = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_result = {24'h000000, w_byte};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: IDLE/REQ/DONE handshake between the pipeline and a RAM
// port, with byte enables, store replication and load extension.
// Optional MEM_TIMEOUT_EN: abandon a REQ with err after TIMEOUT_LIMIT cycles.
module mem_access_unit
   import mem_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ram_enable,
   input  logic        i_rw,
   input  logic [4:0]  i_mem_op,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_rdata,
   output logic        o_ram_req,
   output logic        o_ram_we,
   output logic [31:0] o_ram_addr,
   output logic [3:0]  o_ram_be,
   output logic [31:0] o_ram_wdata,
   input  logic        i_ram_ack,
   input  logic [31:0] i_ram_rdata
);

   state_t   r_state, w_state_nxt;
   logic     r_err, w_err_nxt;
   mem_req_t r_req;
   logic [31:0] r_rdata;
   logic        w_in_fault;
   logic        w_timeout;
   logic [31:0] w_load_data;
   size_t       w_size;
   logic [NUM_LANES-1:0][7:0] w_lane;

   assign w_in_fault = op_fault(i_rw, i_mem_op, i_addr[1:0]);
   assign w_size     = op_size(r_req.op);

`ifdef MEM_TIMEOUT_EN
   logic [TMO_W-1:0] r_tmo_cnt;

   // Counter is held at zero outside REQ, so it starts from zero on every entry.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state != ST_REQ)) r_tmo_cnt <= '0;
      else if (!i_ram_ack)                r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   // Fires in the REQ cycle whose increment would take the count to the limit.
   assign w_timeout = (r_state == ST_REQ) && !i_ram_ack &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_LIMIT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register; err is latched alongside the move into DONE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state logic; faulted ops skip REQ entirely.
   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_ram_enable) begin
               if (w_in_fault) begin
                  w_state_nxt = ST_DONE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (i_ram_ack) begin
               w_state_nxt = ST_DONE;
            end else if (w_timeout) begin
               w_state_nxt = ST_DONE;
               w_err_nxt   = 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Status and RAM strobes decoded from the current state.
   always_comb begin
      o_busy    = (r_state != ST_IDLE);
      o_done    = (r_state == ST_DONE);
      o_err     = (r_state == ST_DONE) && r_err;
      o_ram_req = (r_state == ST_REQ);
      o_ram_we  = (r_state == ST_REQ) && !r_req.rw;
   end

   // Capture the request in IDLE; load result is taken on the ack edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_req   <= '0;
         r_rdata <= '0;
      end else begin
         if ((r_state == ST_IDLE) && i_ram_enable)
            r_req <= '{rw: i_rw, op: i_mem_op, addr: i_addr, wdata: i_wdata};
         if ((r_state == ST_REQ) && i_ram_ack && r_req.rw)
            r_rdata <= w_load_data;
      end
   end

   mem_load_align u_align (
      .i_word   (i_ram_rdata),
      .i_addr   (r_req.addr[1:0]),
      .i_mem_op (r_req.op),
      .o_result (w_load_data)
   );

   // Store replication: each lane takes the item byte that maps onto it.
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign w_lane[k] = (w_size == SZ_WORD) ? r_req.wdata[8*k +: 8]     :
                         (w_size == SZ_HALF) ? r_req.wdata[8*(k%2) +: 8] :
                         (w_size == SZ_BYTE) ? r_req.wdata[7:0]          : 8'h00;
   end

   assign o_ram_addr  = {r_req.addr[31:2], 2'b00};
   assign o_ram_be    = op_be(r_req.op, r_req.addr[1:0]);
   assign o_ram_wdata = w_lane;
   assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: randomized ops against a byte-level
// reference model; a RAM responder checks the request side, a monitor checks
// completions. Honors MEM_TIMEOUT_EN to select the expected REQ behaviour.
module tb_mem_access_unit;

   logic        clk;
   logic        i_reset, i_ram_enable, i_rw, i_ram_ack;
   logic [4:0]  i_mem_op;
   logic [31:0] i_addr, i_wdata, i_ram_rdata;
   logic        o_busy, o_done, o_err, o_ram_req, o_ram_we;
   logic [31:0] o_rdata, o_ram_addr, o_ram_wdata;
   logic [3:0]  o_ram_be;

   mem_access_unit dut (
      .i_clk(clk), .i_reset(i_reset), .i_ram_enable(i_ram_enable), .i_rw(i_rw),
      .i_mem_op(i_mem_op), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
      .o_ram_req(o_ram_req), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
      .o_ram_be(o_ram_be), .o_ram_wdata(o_ram_wdata),
      .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic err; logic [31:0] rdata; } comp_t;
   typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } ram_exp_t;

   comp_t    exp_q[$];
   ram_exp_t ram_q[$];
   int n_checks = 0, n_fail = 0;
   int ack_delay = 0;
   logic [31:0] rd_word = '0;
   logic [31:0] m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---- reference model, in bytes and shifts ----
   function automatic int m_nb(input logic [4:0] op);
      case (op)
         5'd8, 5'd13:        return 4;
         5'd9, 5'd11, 5'd14: return 2;
         5'd10, 5'd12, 5'd15: return 1;
         default:            return 0;
      endcase
   endfunction

   function automatic logic m_is_load(input logic [4:0] op);
      return (op >= 5'd8) && (op <= 5'd12);
   endfunction

   function automatic logic m_fault(input logic rw, input logic [4:0] op, input logic [1:0] a);
      int nb = m_nb(op);
      if (nb == 0) return 1'b1;
      if ((int'(a) % nb) != 0) return 1'b1;
      return rw != m_is_load(op);
   endfunction

   function automatic logic [31:0] m_load(input logic [4:0] op, input logic [31:0] word,
                                          input logic [1:0] a);
      int nb = m_nb(op);
      logic [31:0] v, mask;
      if (nb == 4) return word;
      v    = word >> (8 * int'(a));
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v    = v & mask;
      if (((op == 5'd10) || (op == 5'd11)) && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic ram_exp_t m_ram(input logic rw, input logic [4:0] op,
                                      input logic [31:0] addr, input logic [31:0] wdata);
      ram_exp_t r;
      int nb = m_nb(op);
      logic [7:0] fullbe;
      r.addr  = addr & 32'hFFFF_FFFC;
      fullbe  = 8'((1 << nb) - 1) << addr[1:0];
      r.be    = fullbe[3:0];
      r.we    = !rw;
      for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wdata[8*(k % nb) +: 8];
      return r;
   endfunction

   // ---- RAM responder: checks request fields every REQ cycle, acks after delay ----
   initial begin
      ram_exp_t cur;
      int req_cyc = 0;
      cur = '{default: '0};
      i_ram_ack = 1'b0;
      i_ram_rdata = '0;
      forever begin
         @(negedge clk);
         if (o_ram_req) begin
            if (req_cyc == 0) begin
               if (ram_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_ram_req at %0t", $time);
               end else cur = ram_q.pop_front();
            end
            chk("ram_addr", o_ram_addr, cur.addr);
            chk("ram_be", 32'(o_ram_be), 32'(cur.be));
            chk("ram_we", 32'(o_ram_we), 32'(cur.we));
            if (cur.we) chk("ram_wdata", o_ram_wdata, cur.wdata);
            if (req_cyc >= ack_delay) begin
               i_ram_ack = 1'b1; i_ram_rdata = rd_word;
            end else begin
               i_ram_ack = 1'b0; i_ram_rdata = $urandom;
            end
            req_cyc++;
         end else begin
            req_cyc = 0;
            i_ram_ack = ($urandom_range(0, 3) == 0);
            i_ram_rdata = $urandom;
         end
      end
   end

   // ---- completion monitor ----
   initial begin
      comp_t e;
      forever begin
         @(negedge clk);
         if (o_err && !o_done) begin
            n_checks++; n_fail++;
            $display("FAIL err_without_done at %0t", $time);
         end
         if (o_done) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL spurious_done at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("done_err", 32'(o_err), 32'(e.err));
               chk("done_rdata", o_rdata, e.rdata);
            end
         end
      end
   end

   // ---- driver ----
   task automatic do_op(input logic rw, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word, input int d);
      logic flt, tmo, got;
      int busy_cnt, exp_busy;
      comp_t ce;
      flt = m_fault(rw, op, addr[1:0]);
`ifdef MEM_TIMEOUT_EN
      tmo = !flt && (d >= 15);
`else
      tmo = 1'b0;
`endif
      if (!flt) ram_q.push_back(m_ram(rw, op, addr, wdata));
      rd_word = word;
      ack_delay = d;
      if (!flt && !tmo && rw) m_rdata = m_load(op, word, addr[1:0]);
      ce.err = flt || tmo;
      ce.rdata = m_rdata;
      exp_q.push_back(ce);
      exp_busy = flt ? 1 : (tmo ? 16 : d + 2);

      @(posedge clk); #1;
      i_ram_enable = 1'b1; i_rw = rw; i_mem_op = op; i_addr = addr; i_wdata = wdata;
      @(posedge clk); #1;
      i_ram_enable = ($urandom_range(0, 1) == 1);
      i_rw = 1'($urandom); i_mem_op = 5'($urandom); i_addr = $urandom; i_wdata = $urandom;
      busy_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (o_busy) busy_cnt++;
         if (o_done) got = 1'b1;
         else begin
            i_ram_enable = ($urandom_range(0, 1) == 1);
            i_rw = 1'($urandom); i_mem_op = 5'($urandom); i_addr = $urandom;
         end
`ifndef MEM_TIMEOUT_EN
         if (c == 100 && d >= 100) begin
            chk("stuck_busy", 32'(o_busy), 32'd1);
            chk("stuck_ram_req", 32'(o_ram_req), 32'd1);
            ack_delay = 0;
         end
`endif
      end
      i_ram_enable = 1'b0;
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL done_wait_expired op=%0d addr=0x%08h", op, addr);
      end else if (d < 100 || tmo) begin
         chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
      chk({tag, "_ram_req"}, 32'(o_ram_req), 32'd0);
      chk({tag, "_ram_we"}, 32'(o_ram_we), 32'd0);
      chk({tag, "_ram_be"}, 32'(o_ram_be), 32'd0);
      chk({tag, "_ram_addr"}, o_ram_addr, 32'd0);
      chk({tag, "_ram_wdata"}, o_ram_wdata, 32'd0);
      chk({tag, "_rdata"}, o_rdata, 32'd0);
   endtask

   // Reset lands in the second REQ cycle of a store; the op must vanish.
   task automatic reset_mid_req();
      ram_q.push_back(m_ram(1'b0, 5'd15, 32'h0000_0041, 32'h0000_005A));
      ack_delay = 1000;
      @(posedge clk); #1;
      i_ram_enable = 1'b1; i_rw = 1'b0; i_mem_op = 5'd15; i_addr = 32'h41; i_wdata = 32'h5A;
      @(posedge clk); #1;
      i_ram_enable = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_ram_req", 32'(o_ram_req), 32'd1);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      m_rdata = '0;
      chk_reset_vals("rst_mid");
      repeat (4) @(negedge clk);
      ack_delay = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] addr;
      logic        rw;
      i_reset = 1'b1; i_ram_enable = 1'b0; i_rw = 1'b0; i_mem_op = '0;
      i_addr = '0; i_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      @(posedge clk); #1;
      i_reset = 1'b0;

      do_op(1'b1, 5'd10, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);   // LB
      chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
      do_op(1'b0, 5'd14, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1);   // SH
      do_op(1'b1, 5'd8, 32'h0000_0101, 32'h0, 32'h1111_1111, 0);    // LW misaligned
      chk("lw_fault_rdata_held", o_rdata, 32'hFFFF_FF80);
      do_op(1'b1, 5'd9, 32'h0000_0002, 32'h0, 32'h8001_0000, 4);    // LHU delayed
      chk("lhu_rdata", o_rdata, 32'h0000_8001);
      do_op(1'b0, 5'd9, 32'h0000_0004, 32'h0, 32'h0, 0);            // load code, rw=0
      do_op(1'b1, 5'd13, 32'h0000_0008, 32'h0, 32'h0, 0);           // store code, rw=1
      do_op(1'b1, 5'd3, 32'h0000_0000, 32'h0, 32'h0, 0);            // undefined code

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) op = 5'($urandom);
         else op = 5'd8 + 5'($urandom_range(0, 7));
         rw = m_is_load(op);
         if ($urandom_range(0, 9) == 0) rw = !rw;
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         do_op(rw, op, addr, $urandom, $urandom, $urandom_range(0, 6));
      end

      reset_mid_req();
      do_op(1'b1, 5'd12, 32'h0000_0301, 32'h0, 32'h00C3_0000, 2);   // LBU after reset
      do_op(1'b0, 5'd13, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 1000); // SW, no ack

      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_completions: %0d left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
